// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared definitions for the ALU op sequencer: function codes, the
//   controller state encoding and small classification helpers.
//   Optional feature macro: ALU_SEQ_MULDIV_EN (MULT/DIV sequencing, HI/LO).
package alu_seq_pkg;

   // Function codes understood by the combinational ALU
   localparam logic [5:0] FUNC_ADD   = 6'b100000;
   localparam logic [5:0] FUNC_ADDU  = 6'b100001;
   localparam logic [5:0] FUNC_SUB   = 6'b100010;
   localparam logic [5:0] FUNC_SUBU  = 6'b100011;
   localparam logic [5:0] FUNC_AND   = 6'b100100;
   localparam logic [5:0] FUNC_OR    = 6'b100101;
   localparam logic [5:0] FUNC_XOR   = 6'b100110;
   localparam logic [5:0] FUNC_NOR   = 6'b100111;
   localparam logic [5:0] FUNC_SLT   = 6'b101010;
   localparam logic [5:0] FUNC_SLTU  = 6'b101011;
   localparam logic [5:0] FUNC_BLTZ  = 6'b111000;
   localparam logic [5:0] FUNC_BGEZ  = 6'b111001;
   localparam logic [5:0] FUNC_BEQ   = 6'b111010;
   localparam logic [5:0] FUNC_BNE   = 6'b111011;
   localparam logic [5:0] FUNC_BLEZ  = 6'b111110;
   localparam logic [5:0] FUNC_BGTZ  = 6'b111111;

   // Codes handled by the sequencer itself (HI/LO unit)
   localparam logic [5:0] FUNC_MFHI  = 6'b010000;
   localparam logic [5:0] FUNC_MFLO  = 6'b010010;
   localparam logic [5:0] FUNC_MULT  = 6'b011000;
   localparam logic [5:0] FUNC_MULTU = 6'b011001;
   localparam logic [5:0] FUNC_DIV   = 6'b011010;
   localparam logic [5:0] FUNC_DIVU  = 6'b011011;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      EXEC = 3'd1,
      MUL  = 3'd2,
      DIV  = 3'd3,
      FIX  = 3'd4,
      RESP = 3'd5
   } state_e;

   // Only 1110xx reports a branch outcome (11100x is contained in it)
   function automatic logic is_branch_func(input logic [5:0] f);
      return (f[5:2] == 4'b1110);
   endfunction

   // Funcs that are forwarded to the external ALU
   function automatic logic is_alu_func(input logic [5:0] f);
      return (f[5:3] == 3'b100) || (f == FUNC_SLT) || (f == FUNC_SLTU) ||
             (f[5:3] == 3'b111);
   endfunction

   function automatic logic is_mul_func(input logic [5:0] f);
      return (f[5:1] == 5'b01100);
   endfunction

   function automatic logic is_div_func(input logic [5:0] f);
      return (f[5:1] == 5'b01101);
   endfunction

   // Even codes of the MULT/DIV pairs are the signed variants
   function automatic logic is_signed_muldiv(input logic [5:0] f);
      return !f[0];
   endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv
//   Iterative multiply/divide engine owning HI/LO. Multiply is shift-add
//   using the external ALU adder for the partial sum; divide is restoring
//   with an internal 33-bit compare/subtract. Signed ops work on
//   magnitudes and are corrected in the fixup step.
// Ports
//   clk_in, reset_in          clock, synchronous active-high reset
//   start_in                  load operands (accept of a MULT*/DIV* op)
//   func_in, a_in, b_in       request func and operands
//   mul_step_in, div_step_in  perform one iteration this cycle
//   fix_in                    apply sign fixup this cycle
//   alu_o_in                  ALU sum for the multiply partial add
//   last_out                  current iteration is the 32nd
//   alu_drive_out, alu_a_out, alu_b_out   ALU request for the partial add
//   hi_out, lo_out            HI/LO registers
//   lo_next_out               value LO takes at the next edge
// Only instantiated when ALU_SEQ_MULDIV_EN is defined.
module alu_seq_muldiv
   import alu_seq_pkg::*;
#(
   parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic        start_in,
   input  logic [5:0]  func_in,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   input  logic        mul_step_in,
   input  logic        div_step_in,
   input  logic        fix_in,
   input  logic [31:0] alu_o_in,
   output logic        last_out,
   output logic        alu_drive_out,
   output logic [31:0] alu_a_out,
   output logic [31:0] alu_b_out,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic [31:0] lo_next_out
);

   logic [31:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        neg_a_q, neg_a_d, neg_b_q, neg_b_d;
   logic        is_div_q, is_div_d, div0_q, div0_d;

   logic        neg_a, neg_b, carry, ge;
   logic [31:0] mag_a, mag_b, sum;
   logic [32:0] rem, diff;

   // Partial add only happens when the multiplier LSB (LO[0]) is set
   assign alu_drive_out = mul_step_in && lo_q[0];
   assign alu_a_out     = alu_drive_out ? hi_q   : 32'h0;
   assign alu_b_out     = alu_drive_out ? opnd_q : 32'h0;
   assign last_out      = (cnt_q == 5'd31);
   assign hi_out        = hi_q;
   assign lo_out        = lo_q;
   assign lo_next_out   = lo_d;

   always_comb begin
      hi_d     = hi_q;
      lo_d     = lo_q;
      opnd_d   = opnd_q;
      cnt_d    = cnt_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      is_div_d = is_div_q;
      div0_d   = div0_q;

      neg_a = is_signed_muldiv(func_in) && a_in[31];
      neg_b = is_signed_muldiv(func_in) && b_in[31];
      mag_a = neg_a ? (32'd0 - a_in) : a_in;
      mag_b = neg_b ? (32'd0 - b_in) : b_in;

      // Unsigned overflow of the ALU sum is the carry into HI
      carry = alu_drive_out && (alu_o_in < alu_b_out);
      sum   = alu_drive_out ? alu_o_in : hi_q;

      rem  = {hi_q, lo_q[31]};
      diff = rem - {1'b0, opnd_q};
      ge   = (rem >= {1'b0, opnd_q});

      if (start_in) begin
         cnt_d    = 5'd0;
         neg_a_d  = neg_a;
         neg_b_d  = neg_b;
         is_div_d = is_div_func(func_in);
         div0_d   = is_div_func(func_in) && (b_in == 32'h0);
         if (!is_div_func(func_in)) begin
            hi_d   = 32'h0;
            lo_d   = mag_b;
            opnd_d = mag_a;
         end else if (b_in == 32'h0) begin
            hi_d   = a_in;
            lo_d   = DIV0_LO;
            opnd_d = 32'h0;
         end else begin
            hi_d   = 32'h0;
            lo_d   = mag_a;
            opnd_d = mag_b;
         end
      end else if (mul_step_in) begin
         {hi_d, lo_d} = {carry, sum, lo_q[31:1]};
         cnt_d        = cnt_q + 5'd1;
      end else if (div_step_in) begin
         hi_d  = ge ? diff[31:0] : rem[31:0];
         lo_d  = {lo_q[30:0], ge};
         cnt_d = cnt_q + 5'd1;
      end else if (fix_in && !div0_q) begin
         if (!is_div_q) begin
            if (neg_a_q ^ neg_b_q) begin
               {hi_d, lo_d} = 64'd0 - {hi_q, lo_q};
            end
         end else begin
            lo_d = (neg_a_q ^ neg_b_q) ? (32'd0 - lo_q) : lo_q;
            hi_d = neg_a_q ? (32'd0 - hi_q) : hi_q;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         hi_q     <= 32'h0;
         lo_q     <= 32'h0;
         opnd_q   <= 32'h0;
         cnt_q    <= 5'd0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         is_div_q <= 1'b0;
         div0_q   <= 1'b0;
      end else begin
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         opnd_q   <= opnd_d;
         cnt_q    <= cnt_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         is_div_q <= is_div_d;
         div0_q   <= div0_d;
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Front-end controller for the combinational 32-bit execute-stage ALU.
//   Takes one op per request handshake, drives the ALU Func/A/B ports for
//   one EXEC cycle, and registers O/Branch into a response held until the
//   consumer takes it.
// Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high; valid, once raised, holds its payload stable until that edge.
// Optional feature macro: ALU_SEQ_MULDIV_EN adds MULT/MULTU/DIV/DIVU
//   sequencing (alu_seq_muldiv) plus HI/LO and MFHI/MFLO. Without it those
//   six codes answer with err=1.
// Ports
//   Clk_in, Reset_in                         clock, sync active-high reset
//   Req_valid_in/Req_ready_out               request handshake
//   Req_func_in, Req_a_in, Req_b_in, Req_tag_in   request payload
//   Alu_func_out, Alu_a_out, Alu_b_out       to ALU (zero when idle)
//   Alu_o_in, Alu_branch_in                  from ALU
//   Rsp_valid_out/Rsp_ready_in               response handshake
//   Rsp_data_out, Rsp_branch_out, Rsp_err_out, Rsp_tag_out  response payload
//   Busy_out                                 controller not idle
//   State_dbg_out                            current controller state
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int          TAG_W   = 4,
   parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
   input  logic             Clk_in,
   input  logic             Reset_in,
   input  logic             Req_valid_in,
   output logic             Req_ready_out,
   input  logic [5:0]       Req_func_in,
   input  logic [31:0]      Req_a_in,
   input  logic [31:0]      Req_b_in,
   input  logic [TAG_W-1:0] Req_tag_in,
   output logic [5:0]       Alu_func_out,
   output logic [31:0]      Alu_a_out,
   output logic [31:0]      Alu_b_out,
   input  logic [31:0]      Alu_o_in,
   input  logic             Alu_branch_in,
   output logic             Rsp_valid_out,
   input  logic             Rsp_ready_in,
   output logic [31:0]      Rsp_data_out,
   output logic             Rsp_branch_out,
   output logic             Rsp_err_out,
   output logic [TAG_W-1:0] Rsp_tag_out,
   output logic             Busy_out,
   output state_e           State_dbg_out
);

   state_e             state_q, state_d;
   logic [5:0]         func_q, func_d;
   logic [31:0]        a_q, a_d, b_q, b_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [31:0]        rsp_data_q, rsp_data_d;
   logic               rsp_branch_q, rsp_branch_d;
   logic               rsp_err_q, rsp_err_d;
   logic               accept;

   assign Req_ready_out  = (state_q == IDLE) && !Reset_in;
   assign accept         = Req_valid_in && Req_ready_out;
   assign Rsp_valid_out  = (state_q == RESP);
   assign Rsp_data_out   = rsp_data_q;
   assign Rsp_branch_out = rsp_branch_q;
   assign Rsp_err_out    = rsp_err_q;
   assign Rsp_tag_out    = tag_q;
   assign Busy_out       = (state_q != IDLE);
   assign State_dbg_out  = state_q;

`ifdef ALU_SEQ_MULDIV_EN
   logic        md_start, md_last, md_drive;
   logic [31:0] md_alu_a, md_alu_b, md_hi, md_lo, md_lo_next;

   assign md_start = accept && (is_mul_func(Req_func_in) || is_div_func(Req_func_in));

   alu_seq_muldiv #(.DIV0_LO(DIV0_LO)) u_muldiv (
      .clk_in        (Clk_in),
      .reset_in      (Reset_in),
      .start_in      (md_start),
      .func_in       (Req_func_in),
      .a_in          (Req_a_in),
      .b_in          (Req_b_in),
      .mul_step_in   (state_q == MUL),
      .div_step_in   (state_q == DIV),
      .fix_in        (state_q == FIX),
      .alu_o_in      (Alu_o_in),
      .last_out      (md_last),
      .alu_drive_out (md_drive),
      .alu_a_out     (md_alu_a),
      .alu_b_out     (md_alu_b),
      .hi_out        (md_hi),
      .lo_out        (md_lo),
      .lo_next_out   (md_lo_next)
   );
`else
   logic unused_div0_lo;
   assign unused_div0_lo = ^DIV0_LO;
`endif

   // ALU port mux: ops owned by the sequencer leave the ALU at zero
   always_comb begin
      Alu_func_out = 6'b0;
      Alu_a_out    = 32'h0;
      Alu_b_out    = 32'h0;
      if ((state_q == EXEC) && is_alu_func(func_q)) begin
         Alu_func_out = func_q;
         Alu_a_out    = a_q;
         Alu_b_out    = b_q;
      end
`ifdef ALU_SEQ_MULDIV_EN
      if ((state_q == MUL) && md_drive) begin
         Alu_func_out = FUNC_ADDU;
         Alu_a_out    = md_alu_a;
         Alu_b_out    = md_alu_b;
      end
`endif
   end

   always_comb begin
      state_d      = state_q;
      func_d       = func_q;
      a_d          = a_q;
      b_d          = b_q;
      tag_d        = tag_q;
      rsp_data_d   = rsp_data_q;
      rsp_branch_d = rsp_branch_q;
      rsp_err_d    = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               func_d  = Req_func_in;
               a_d     = Req_a_in;
               b_d     = Req_b_in;
               tag_d   = Req_tag_in;
               state_d = EXEC;
`ifdef ALU_SEQ_MULDIV_EN
               // Divide by zero skips the iterations and goes straight to FIX
               if (is_mul_func(Req_func_in)) begin
                  state_d = MUL;
               end else if (is_div_func(Req_func_in)) begin
                  state_d = (Req_b_in == 32'h0) ? FIX : DIV;
               end
`endif
            end
         end
         EXEC: begin
            rsp_branch_d = 1'b0;
            rsp_err_d    = 1'b0;
            if (is_alu_func(func_q)) begin
               rsp_data_d   = Alu_o_in;
               rsp_branch_d = is_branch_func(func_q) && Alu_branch_in;
            end
`ifdef ALU_SEQ_MULDIV_EN
            else if (func_q == FUNC_MFHI) begin
               rsp_data_d = md_hi;
            end else if (func_q == FUNC_MFLO) begin
               rsp_data_d = md_lo;
            end
`endif
            else begin
               rsp_data_d = 32'h0;
               rsp_err_d  = 1'b1;
            end
            state_d = RESP;
         end
`ifdef ALU_SEQ_MULDIV_EN
         MUL, DIV: begin
            if (md_last) state_d = FIX;
         end
         FIX: begin
            // LO is updated by the fixup on this same edge, so take its next value
            rsp_data_d   = md_lo_next;
            rsp_branch_d = 1'b0;
            rsp_err_d    = 1'b0;
            state_d      = RESP;
         end
`endif
         RESP: begin
            if (Rsp_ready_in) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk_in) begin
      if (Reset_in) begin
         state_q      <= IDLE;
         func_q       <= 6'b0;
         a_q          <= 32'h0;
         b_q          <= 32'h0;
         tag_q        <= '0;
         rsp_data_q   <= 32'h0;
         rsp_branch_q <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         func_q       <= func_d;
         a_q          <= a_d;
         b_q          <= b_d;
         tag_q        <= tag_d;
         rsp_data_q   <= rsp_data_d;
         rsp_branch_q <= rsp_branch_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//   Directed bench for alu_op_sequencer with a small behavioural ALU model.
//   MULT/DIV/MFHI/MFLO vectors are selected by ALU_SEQ_MULDIV_EN.
module tb_alu_op_sequencer;
   import alu_seq_pkg::*;

   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid, req_ready;
   logic [5:0]       req_func;
   logic [31:0]      req_a, req_b;
   logic [TAG_W-1:0] req_tag;
   logic [5:0]       alu_func;
   logic [31:0]      alu_a, alu_b, alu_o;
   logic             alu_branch, tb_branch;
   logic             rsp_valid, rsp_ready;
   logic [31:0]      rsp_data;
   logic             rsp_branch, rsp_err;
   logic [TAG_W-1:0] rsp_tag;
   logic             busy;
   state_e           state_dbg;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   alu_op_sequencer #(.TAG_W(TAG_W), .DIV0_LO(32'hFFFF_FFFF)) dut (
      .Clk_in         (clk),
      .Reset_in       (rst),
      .Req_valid_in   (req_valid),
      .Req_ready_out  (req_ready),
      .Req_func_in    (req_func),
      .Req_a_in       (req_a),
      .Req_b_in       (req_b),
      .Req_tag_in     (req_tag),
      .Alu_func_out   (alu_func),
      .Alu_a_out      (alu_a),
      .Alu_b_out      (alu_b),
      .Alu_o_in       (alu_o),
      .Alu_branch_in  (alu_branch),
      .Rsp_valid_out  (rsp_valid),
      .Rsp_ready_in   (rsp_ready),
      .Rsp_data_out   (rsp_data),
      .Rsp_branch_out (rsp_branch),
      .Rsp_err_out    (rsp_err),
      .Rsp_tag_out    (rsp_tag),
      .Busy_out       (busy),
      .State_dbg_out  (state_dbg)
   );

   // Behavioural ALU; the branch outcome is set directly by each vector
   always_comb begin
      case (alu_func)
         FUNC_ADD, FUNC_ADDU: alu_o = alu_a + alu_b;
         FUNC_SUB, FUNC_SUBU: alu_o = alu_a - alu_b;
         FUNC_AND:            alu_o = alu_a & alu_b;
         FUNC_OR:             alu_o = alu_a | alu_b;
         FUNC_XOR:            alu_o = alu_a ^ alu_b;
         FUNC_NOR:            alu_o = ~(alu_a | alu_b);
         default:             alu_o = 32'h0;
      endcase
   end
   assign alu_branch = tb_branch;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] t);
      int n;
      n = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_func  = f;
      req_a     = a;
      req_b     = b;
      req_tag   = t;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("accept_wait", 32'(n < 100), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // Cycles counted from the accept cycle (=1) to the first cycle with valid high
   task automatic wait_valid(output int cyc);
      cyc = 1;
      while (!rsp_valid && cyc < 60) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic consume(input string name);
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check({name, "_valid_drop"}, 32'(rsp_valid), 32'd0);
      check({name, "_ready_back"}, 32'(req_ready), 32'd1);
   endtask

   task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] t,
                         input logic [5:0] exp_alu_f, input logic [31:0] exp_data,
                         input logic exp_br, input logic exp_err, input int exp_cyc);
      int cyc;
      logic [31:0] exp_d;
      exp_q.push_back(exp_data);
      issue(f, a, b, t);
      check({name, "_alu_func"}, 32'(alu_func), 32'(exp_alu_f));
      check({name, "_busy"}, 32'(busy), 32'd1);
      wait_valid(cyc);
      check({name, "_latency"}, cyc, exp_cyc);
      exp_d = exp_q.pop_front();
      check({name, "_data"}, rsp_data, exp_d);
      check({name, "_branch"}, 32'(rsp_branch), 32'(exp_br));
      check({name, "_err"}, 32'(rsp_err), 32'(exp_err));
      check({name, "_tag"}, 32'(rsp_tag), 32'(t));
      consume(name);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cyc;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_func  = 6'b0;
      req_a     = 32'h0;
      req_b     = 32'h0;
      req_tag   = '0;
      rsp_ready = 1'b0;
      tb_branch = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready_in_reset", 32'(req_ready), 32'd0);
      check("rst_alu_func", 32'(alu_func), 32'd0);
      check("rst_data", rsp_data, 32'h0);
      check("rst_tag", 32'(rsp_tag), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_ready_after", 32'(req_ready), 32'd1);

      // Plain ALU ops
      run_op("addu", FUNC_ADDU, 32'h1, 32'hFFFF_FFFE, 4'd3, FUNC_ADDU, 32'hFFFF_FFFF, 1'b0, 1'b0, 2);
      tb_branch = 1'b1;
      run_op("bltz", FUNC_BLTZ, 32'hFFFF_FFFF, 32'h0, 4'd4, FUNC_BLTZ, 32'h0, 1'b1, 1'b0, 2);
      run_op("bne", FUNC_BNE, 32'h0, 32'h1, 4'd5, FUNC_BNE, 32'h0, 1'b1, 1'b0, 2);
      run_op("add", FUNC_ADD, 32'h6, 32'hFFFF_FFFE, 4'd6, FUNC_ADD, 32'h4, 1'b0, 1'b0, 2);
      tb_branch = 1'b0;
      run_op("xor", FUNC_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 4'd7, FUNC_XOR, 32'hFF00_EDCB, 1'b0, 1'b0, 2);
      run_op("unsup", 6'b000101, 32'h5, 32'h5, 4'd8, 6'b0, 32'h0, 1'b0, 1'b1, 2);

      // Backpressure: response held, next request waits, accepted right after the handshake
      issue(FUNC_ADDU, 32'd5, 32'd3, 4'd9);
      wait_valid(cyc);
      check("bp_latency", cyc, 2);
      @(negedge clk);
      req_valid = 1'b1;
      req_func  = FUNC_SUBU;
      req_a     = 32'd10;
      req_b     = 32'd4;
      req_tag   = 4'd1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp_data", rsp_data, 32'd8);
         check("bp_valid", 32'(rsp_valid), 32'd1);
         check("bp_req_ready", 32'(req_ready), 32'd0);
         check("bp_tag", 32'(rsp_tag), 32'd9);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check("bp_valid_drop", 32'(rsp_valid), 32'd0);
      check("bp_ready_back", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("bp_next_busy", 32'(busy), 32'd1);
      check("bp_next_state", 32'(state_dbg), 32'(EXEC));
      wait_valid(cyc);
      check("bp_next_latency", cyc, 2);
      check("bp_next_data", rsp_data, 32'd6);
      check("bp_next_tag", 32'(rsp_tag), 32'd1);
      consume("bp_next");

`ifdef ALU_SEQ_MULDIV_EN
      run_op("mult", FUNC_MULT, 32'hFFFF_FFFD, 32'h7, 4'd2, FUNC_ADDU, 32'hFFFF_FFEB, 1'b0, 1'b0, 34);
      run_op("mfhi_mult", FUNC_MFHI, 32'h0, 32'h0, 4'd3, 6'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 2);
      run_op("mflo_mult", FUNC_MFLO, 32'h0, 32'h0, 4'd4, 6'b0, 32'hFFFF_FFEB, 1'b0, 1'b0, 2);
      run_op("multu", FUNC_MULTU, 32'h0001_0000, 32'h0003_0000, 4'd5, 6'b0, 32'h0, 1'b0, 1'b0, 34);
      run_op("mfhi_multu", FUNC_MFHI, 32'h0, 32'h0, 4'd6, 6'b0, 32'h0000_0003, 1'b0, 1'b0, 2);
      run_op("divu0", FUNC_DIVU, 32'h7, 32'h0, 4'd7, 6'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 2);
      run_op("mfhi_div0", FUNC_MFHI, 32'h0, 32'h0, 4'd8, 6'b0, 32'h7, 1'b0, 1'b0, 2);
      run_op("div", FUNC_DIV, 32'hFFFF_FFF9, 32'h2, 4'd9, 6'b0, 32'hFFFF_FFFD, 1'b0, 1'b0, 34);
      run_op("mfhi_div", FUNC_MFHI, 32'h0, 32'h0, 4'd10, 6'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 2);
      run_op("divu", FUNC_DIVU, 32'd100, 32'd7, 4'd11, 6'b0, 32'd14, 1'b0, 1'b0, 34);
      run_op("mfhi_divu", FUNC_MFHI, 32'h0, 32'h0, 4'd12, 6'b0, 32'd2, 1'b0, 1'b0, 2);

      // Reset in the middle of a multiply aborts it and clears HI/LO
      issue(FUNC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd13);
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (rsp_valid) check("abort_no_rsp", 32'(rsp_valid), 32'd0);
      end
      check("abort_idle", 32'(state_dbg), 32'(IDLE));
      run_op("mfhi_rst", FUNC_MFHI, 32'h0, 32'h0, 4'd14, 6'b0, 32'h0, 1'b0, 1'b0, 2);
      run_op("mflo_rst", FUNC_MFLO, 32'h0, 32'h0, 4'd15, 6'b0, 32'h0, 1'b0, 1'b0, 2);
`else
      run_op("mult_off", FUNC_MULT, 32'hFFFF_FFFD, 32'h7, 4'd2, 6'b0, 32'h0, 1'b0, 1'b1, 2);
      run_op("divu_off", FUNC_DIVU, 32'h7, 32'h0, 4'd3, 6'b0, 32'h0, 1'b0, 1'b1, 2);
      run_op("mfhi_off", FUNC_MFHI, 32'h0, 32'h0, 4'd4, 6'b0, 32'h0, 1'b0, 1'b1, 2);

      // Reset while a response is pending drops it
      issue(FUNC_ADDU, 32'h2, 32'h2, 4'd5);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_ready", 32'(req_ready), 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
